alu_sequencer: RTL and testbench

Shared-ALU controller that arbitrates between two requesters (port 0: execute-stage issue, port 1: cache/address-generation helper) and sequences single-cycle and multi-cycle operations through the single 32-bit combinational ALU. Operands and opcode are registered so the ALU inputs stay stable for the full operation. The result is captured and returned to the owning requester with a one-cycle valid pulse. The block sits between the pipeline control logic and the ALU instance.

---
 rtl/alu_sequencer_if.sv | 50 +++++
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Signal bundle between alu_sequencer, its two requesters and the shared ALU instance.
// slave: the sequencer itself; master: the environment (requesters + ALU).
interface alu_sequencer_if;
  // Port 0: execute-stage issue
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req0_c;
  // Port 1: cache/address-generation helper
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [31:0] req1_c;
  // Shared response
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  // ALU side
  logic [3:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_in3;
  logic [31:0] alu_out;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_c,
    input  req1_valid, req1_op, req1_a, req1_b, req1_c,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    output alu_op, alu_in1, alu_in2, alu_in3,
    input  alu_out,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_c,
    output req1_valid, req1_op, req1_a, req1_b, req1_c,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    input  alu_op, alu_in1, alu_in2, alu_in3,
    output alu_out,
    input  busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Shared-ALU sequencer: arbitrates two requesters onto one combinational 32-bit ALU.
// Define ALU_SEQ_RR_EN for round-robin arbitration; default build is fixed priority (port 0).
module alu_sequencer #(
  parameter int MUL_LAT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_EXEC
  } state_t;

  localparam logic [3:0] LP_MUL_CNT = 4'(MUL_LAT - 1);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_mul_lat_range
    $error("alu_sequencer: MUL_LAT must be in 1..15");
  end

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0011) || (op == 4'b0100);
  endfunction

  function automatic logic is_undef_op(input logic [3:0] op);
    return op >= 4'b1101;
  endfunction

  state_t      r_state;
  logic [3:0]  r_count;
  logic        r_owner;
  logic        r_undef;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_c;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_grant;
  logic        w_any_valid;
  logic        w_accept;
  logic [3:0]  w_sel_op;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [31:0] w_sel_c;

  assign w_any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ALU_SEQ_RR_EN
  logic r_last_grant;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (bus.req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Reset value marks port 1 as last served, so the first contended grant goes to port 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
    end
  end
`else
  assign w_grant = ~bus.req0_valid & bus.req1_valid;
`endif

  // Ready is forced low while reset is asserted, whatever the state register holds.
  assign w_accept       = rst_n & (r_state == ST_IDLE) & w_any_valid;
  assign bus.req0_ready = w_accept & ~w_grant;
  assign bus.req1_ready = w_accept &  w_grant;

  assign w_sel_op = w_grant ? bus.req1_op : bus.req0_op;
  assign w_sel_a  = w_grant ? bus.req1_a  : bus.req0_a;
  assign w_sel_b  = w_grant ? bus.req1_b  : bus.req0_b;
  assign w_sel_c  = w_grant ? bus.req1_c  : bus.req0_c;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_owner      <= 1'b0;
      r_undef      <= 1'b0;
      // NOTE: operand and result registers are reset as well, so ALU inputs and rsp_data are never X.
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_c     <= w_sel_c;
            r_owner <= w_grant;
            r_undef <= is_undef_op(w_sel_op);
            r_count <= is_mul_op(w_sel_op) ? LP_MUL_CNT : 4'd0;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            r_rsp_data   <= r_undef ? 32'd0 : bus.alu_out;
            r_rsp_err    <= r_undef;
            r_rsp0_valid <= ~r_owner;
            r_rsp1_valid <=  r_owner;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_op     = r_op;
  assign bus.alu_in1    = r_a;
  assign bus.alu_in2    = r_b;
  assign bus.alu_in3    = r_c;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.busy       = (r_state == ST_EXEC);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases followed by a randomized run
// scored against a cycle-level transaction model (arbitration, latency, result, hold).
module tb_alu_sequencer;

  localparam int MUL_LAT    = 3;
  localparam int RND_CYCLES = 3000;
`ifdef ALU_SEQ_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_last;

  alu_sequencer_if bus();

  alu_sequencer #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the ALU instance: distinct function per opcode.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
    case (op)
      4'd0:    return a * b;
      4'd1:    return a - b;
      4'd2:    return a ^ c;
      4'd3:    return a * b + c;
      4'd4:    return a * c - b;
      4'd5:    return (a & b) | c;
      4'd6:    return a + b;
      4'd7:    return a | b;
      4'd8:    return a << b[4:0];
      4'd9:    return a >> c[4:0];
      4'd10:   return ~a;
      4'd11:   return b - c;
      4'd12:   return a + b + c;
      default: return 32'hDEAD_0000 | {28'h0, op};
    endcase
  endfunction

  function automatic bit is_mul(input logic [3:0] op);
    return op inside {4'd0, 4'd3, 4'd4};
  endfunction

  function automatic bit is_undef(input logic [3:0] op);
    return op inside {4'd13, 4'd14, 4'd15};
  endfunction

  always_comb bus.alu_out = alu_fn(bus.alu_op, bus.alu_in1, bus.alu_in2, bus.alu_in3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_c = c;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_c = c;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One isolated request from IDLE; checks ready, busy window and the response pulse.
  task automatic single_op(input int p, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c, input string tag);
    int          lat;
    logic [31:0] exp_data;
    lat      = is_mul(op) ? MUL_LAT : 1;
    exp_data = is_undef(op) ? 32'd0 : alu_fn(op, a, b, c);
    next_cycle();
    drive(p, 1'b1, op, a, b, c);
    sample();
    check({tag, "_ready"}, (p == 0) ? bus.req0_ready : bus.req1_ready, 1);
    for (int k = 1; k <= lat; k++) begin
      next_cycle();
      if (k == 1) drive(p, 1'b0, op, a, b, c);
      sample();
      check($sformatf("%s_busy%0d", tag, k), bus.busy, 1);
      check($sformatf("%s_alu_op%0d", tag, k), bus.alu_op, op);
      check($sformatf("%s_norsp%0d", tag, k), {bus.rsp1_valid, bus.rsp0_valid}, 0);
    end
    next_cycle();
    sample();
    check({tag, "_rsp0"}, bus.rsp0_valid, (p == 0));
    check({tag, "_rsp1"}, bus.rsp1_valid, (p == 1));
    check({tag, "_data"}, bus.rsp_data, exp_data);
    check({tag, "_err"},  bus.rsp_err, is_undef(op));
    check({tag, "_idle"}, bus.busy, 0);
    exp_last = (p == 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    exp_t        q[$];
    exp_t        e;
    logic        v[2];
    logic        acc[2];
    logic [3:0]  op[2];
    logic [31:0] ra[2], rb[2], rc[2];
    logic [31:0] last_data;
    logic        last_err;
    bit          have_last;
    int          free_at;
    int          win;
    int          lat;
    logic        exp_w;

    // ---------------- reset with both valids high ----------------
    drive(0, 1'b1, 4'd1, 32'd20, 32'd8, 32'd0);
    drive(1, 1'b1, 4'd1, 32'd50, 32'd1, 32'd0);
    repeat (2) @(posedge clk);
    sample();
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_rsp",    {bus.rsp1_valid, bus.rsp0_valid}, 0);
    check("rst_data",   bus.rsp_data, 0);
    check("rst_err",    bus.rsp_err, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_in1",    bus.alu_in1, 0);
    check("rst_in2",    bus.alu_in2, 0);
    check("rst_in3",    bus.alu_in3, 0);
    check("rst_busy",   bus.busy, 0);
    next_cycle();
    rst_n = 1'b1;
    sample();
    check("rel_ready0", bus.req0_ready, 1);
    check("rel_ready1", bus.req1_ready, 0);
    next_cycle();
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    sample();
    check("rel_busy", bus.busy, 1);
    next_cycle();
    sample();
    check("rel_rsp0", bus.rsp0_valid, 1);
    check("rel_data", bus.rsp_data, 32'd12);
    exp_last = 1'b0;

    // ---------------- single-cycle add, back-to-back ----------------
    next_cycle();
    drive(0, 1'b1, 4'b0110, 32'd5, 32'd7, 32'd0);
    sample();
    check("add_ready0", bus.req0_ready, 1);
    next_cycle();
    drive(0, 1'b1, 4'b0110, 32'd100, 32'd23, 32'd0);
    sample();
    check("add_busy",    bus.busy, 1);
    check("add_ready_x", bus.req0_ready, 0);
    check("add_norsp",   bus.rsp0_valid, 0);
    next_cycle();
    sample();
    check("add_rsp0",   bus.rsp0_valid, 1);
    check("add_rsp1",   bus.rsp1_valid, 0);
    check("add_data",   bus.rsp_data, 32'd12);
    check("add_err",    bus.rsp_err, 0);
    check("b2b_ready0", bus.req0_ready, 1);
    next_cycle();
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    sample();
    check("b2b_busy", bus.busy, 1);
    next_cycle();
    sample();
    check("b2b_rsp0", bus.rsp0_valid, 1);
    check("b2b_data", bus.rsp_data, 32'd123);

    // ---------------- multiply-class on port 1 ----------------
    single_op(1, 4'b0011, 32'd3, 32'd4, 32'hFFFF_FFFE, "mul");
    check("mul_value", bus.rsp_data, 32'd10);

    // ---------------- undefined opcode ----------------
    single_op(0, 4'b1110, $urandom, $urandom, $urandom, "undef");
    next_cycle();
    sample();
    check("hold_data", bus.rsp_data, 0);
    check("hold_err",  bus.rsp_err, 1);
    check("hold_rsp0", bus.rsp0_valid, 0);

    // ---------------- contention, op 0001 ----------------
    next_cycle();
    drive(0, 1'b1, 4'd1, 32'd9, 32'd2, 32'd0);
    drive(1, 1'b1, 4'd1, 32'd40, 32'd1, 32'd0);
    exp_w = RR ? ~exp_last : 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      sample();
      if (k % 2 == 0) begin
        check($sformatf("cont_ready0_%0d", k), bus.req0_ready, (exp_w == 1'b0));
        check($sformatf("cont_ready1_%0d", k), bus.req1_ready, (exp_w == 1'b1));
        exp_last = exp_w;
        if (RR) exp_w = ~exp_w;
      end else begin
        check($sformatf("cont_none_%0d", k), {bus.req1_ready, bus.req0_ready}, 0);
      end
    end
    next_cycle();
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    sample();
    check("cont_last_rsp", {bus.rsp1_valid, bus.rsp0_valid}, exp_last ? 2'b10 : 2'b01);
    check("cont_last_data", bus.rsp_data, exp_last ? 32'd39 : 32'd7);
    next_cycle();

    // ---------------- reset in 2nd EXEC cycle of a multiply ----------------
    next_cycle();
    drive(1, 1'b1, 4'd3, 32'd7, 32'd9, 32'd5);
    sample();
    check("mrst_ready1", bus.req1_ready, 1);
    next_cycle();
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    sample();
    check("mrst_busy1", bus.busy, 1);
    next_cycle();
    rst_n = 1'b0;
    sample();
    check("mrst_busy2", bus.busy, 1);
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      sample();
      check($sformatf("mrst_norsp_%0d", k), {bus.rsp1_valid, bus.rsp0_valid}, 0);
      check($sformatf("mrst_idle_%0d", k), bus.busy, 0);
    end
    check("mrst_data", bus.rsp_data, 0);
    exp_last = 1'b1;
    single_op(0, 4'd12, 32'd1000, 32'd200, 32'd30, "post_rst");

    // ---------------- randomized run against transaction model ----------------
    free_at   = 0;
    have_last = 1'b0;
    last_data = '0;
    last_err  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; acc[p] = 1'b0; op[p] = '0; ra[p] = '0; rb[p] = '0; rc[p] = '0;
    end
    for (int c = 0; c < RND_CYCLES; c++) begin
      next_cycle();
      for (int p = 0; p < 2; p++) begin
        if (acc[p] || !v[p]) begin
          v[p]  = ($urandom_range(0, 1) == 1);
          op[p] = 4'($urandom_range(0, 15));
          ra[p] = $urandom;
          rb[p] = $urandom;
          rc[p] = $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
          v[p] = 1'b0;
        end
        acc[p] = 1'b0;
        drive(p, v[p], op[p], ra[p], rb[p], rc[p]);
      end
      sample();

      win = -1;
      if (c >= free_at && (v[0] || v[1])) begin
        if (v[0] && v[1]) win = RR ? (exp_last ? 0 : 1) : 0;
        else              win = v[0] ? 0 : 1;
      end

      if (q.size() > 0 && q[0].due == c) begin
        e = q.pop_front();
        check("rnd_rsp0", bus.rsp0_valid, (e.port == 1'b0));
        check("rnd_rsp1", bus.rsp1_valid, (e.port == 1'b1));
        last_data = e.data;
        last_err  = e.err;
        have_last = 1'b1;
      end else begin
        check("rnd_norsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
      end
      if (have_last) begin
        check("rnd_data", bus.rsp_data, last_data);
        check("rnd_err",  bus.rsp_err, last_err);
      end
      check("rnd_ready0", bus.req0_ready, (win == 0));
      check("rnd_ready1", bus.req1_ready, (win == 1));
      check("rnd_busy",   bus.busy, (c < free_at));

      if (win >= 0) begin
        lat = is_mul(op[win]) ? MUL_LAT : 1;
        e.due  = c + lat + 1;
        e.port = (win == 1);
        e.data = is_undef(op[win]) ? 32'd0 : alu_fn(op[win], ra[win], rb[win], rc[win]);
        e.err  = is_undef(op[win]);
        q.push_back(e);
        free_at  = c + lat + 1;
        exp_last = (win == 1);
        acc[win] = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
